alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational alu between two requesters: port 0 is the execute stage, port 1 is the address/auxiliary unit.
- Arbitrates round-robin with valid/ready handshakes and registers the selected result into a one-entry response buffer.
- Tags each response with the requester id.
- Sits in the Execute stage, wrapping one alu instance.

Parameters:
- XLEN, 32, datapath width; taken from core_general.vh.
- FUNCT_W, 4, width of the funct_alu code ({funct7[5], funct3}).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush; discards the buffered response
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_in1  input  XLEN  operand 1
- req0_in2  input  XLEN  operand 2 (shift amount in bits [4:0])
- req0_funct  input  FUNCT_W  ALU operation code
- req1_valid / req1_ready / req1_in1 / req1_in2 / req1_funct  as port 0, for requester 1
- rsp_valid  output  1  response buffer full
- rsp_ready  input  1  consumer takes the response when valid&ready
- rsp_id  output  1  requester index of the buffered response
- rsp_data  output  XLEN  registered ALU result
- rsp_err  output  1  operation code was unsupported

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0
  - last_grant=1, so port 0 wins the first contested cycle
  - Reset mid-transaction drops the buffered result; nothing is replayed.
- Free condition: `free = !rsp_valid | rsp_ready`.
  - The buffer accepts a new operation in the same cycle the old one drains (full throughput, one op/cycle).
- Grant (combinational):
  - Only one valid → that port is granted.
  - Both valid → the port != last_grant is granted.
  - reqN_ready = free & grantN & !flush.
  - At most one ready is high per cycle.
  - A ready never depends on the same port's valid beyond the grant selection.
- Accept: on a clock edge with reqN_valid & reqN_ready:
  - alu operands/funct are muxed from port N.
  - rsp_data <= alu output, rsp_id <= N, rsp_valid <= 1, last_grant <= N.
  - Latency is 1 cycle (accept edge → rsp_valid high).
- Drain without new accept: rsp_valid & rsp_ready & no accept → rsp_valid <= 0; rsp_data/rsp_id hold their value.
- Stall: while rsp_valid & !rsp_ready, rsp_data/rsp_id/rsp_err stay stable and both readys are 0.
- Supported codes:
  - 0000 ADD, 1000 SUB
  - x001 SLL
  - x100 XOR
  - 0101 SRL, 1101 SRA
  - x110 OR
  - x111 AND
- Unsupported codes (x010, x011):
  - Still accepted.
  - rsp_err <= 1, rsp_data <= 0; the alu's X output must never reach rsp_data.
- Width rules:
  - Shifts use in2[4:0] only.
  - Arithmetic wraps modulo 2^XLEN; no carry or overflow output.
- Flush:
  - Next edge clears rsp_valid and rsp_err; no accept occurs in a flush cycle.
  - Flush has priority over a simultaneous accept and drain.
  - last_grant is unchanged.
- Requester rules (the bench checks these): a requester holds valid and its operands stable until accepted; the arbiter does not latch requests.

Decomposition:
- Shared package/header (core_general.vh):
  - XLEN
  - funct_alu code constants (ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND)
  - a helper identifying unsupported codes
- Sub-module: the existing alu, instantiated once.
- Arbitration and the response register live in this module. Optionally split out rr_arb2 (2-way round-robin grant) if reused by the memory port.

Test Plan:
- Single request, free buffer: req0 in1=0x17, in2=0x0A, funct=0000, rsp_ready=1 → req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x21, rsp_err=0.
- Contention, alternating grants: both valid every cycle (port0 SUB 0x17-0x0A, port1 AND 0x17&0x0A), rsp_ready=1 → grants in order 0,1,0,1; responses 0x0D id0, 0x02 id1, 0x0D id0…; one accept per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after a buffered SRA (in1=0x80000015, in2=3) → rsp_data=0xF0000002 held stable, both readys 0; on rsp_ready=1 the pending req1 is accepted in the same cycle.
- Unsupported op: funct=0011, in1=0x80000015, in2=3 → rsp_valid=1, rsp_err=1, rsp_data=0x00000000 (no X on any output).
- Flush: buffered result plus req0 valid; assert flush with rsp_ready=1 → next cycle rsp_valid=0 and req0 not accepted; the following cycle req0 is accepted.
- Async reset mid-stall: rst_n low between clock edges while rsp_valid=1 → rsp_valid/rsp_data/rsp_id/rsp_err go to 0 immediately; after release, contended first grant goes to port 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: datapath width, ALU operation codes
// and a helper that recognises operation codes the ALU does not implement.
package alu_arbiter_pkg;
  localparam int XLEN    = 32;
  localparam int FUNCT_W = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  // x010 and x011 have no ALU operation behind them
  function automatic logic alu_unsupported(input logic [3:0] funct);
    return funct[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; funct is {funct7[5], funct3}, shifts use in2[4:0] only.
module alu_arbiter_alu #(
  parameter int XLEN    = 32,
  parameter int FUNCT_W = 4
) (
  input  logic [XLEN-1:0]    in1_i,
  input  logic [XLEN-1:0]    in2_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [XLEN-1:0]    result_o
);
  import alu_arbiter_pkg::*;

  logic [4:0] shamt;
  assign shamt = in2_i[4:0];

  always_comb begin
    result_o = '0;
    case (funct_i[2:0])
      ALU_ADD[2:0]: result_o = (funct_i == ALU_SUB) ? in1_i - in2_i : in1_i + in2_i;
      ALU_SLL[2:0]: result_o = in1_i << shamt;
      ALU_XOR[2:0]: result_o = in1_i ^ in2_i;
      ALU_SRL[2:0]: result_o = (funct_i == ALU_SRA) ? $unsigned($signed(in1_i) >>> shamt)
                                                   : in1_i >> shamt;
      ALU_OR[2:0]:  result_o = in1_i | in2_i;
      ALU_AND[2:0]: result_o = in1_i & in2_i;
      default:      result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared ALU, with a one-entry
// response buffer tagged by requester id.
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_in1,
  input  logic [XLEN-1:0]    req0_in2,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_in1,
  input  logic [XLEN-1:0]    req1_in2,
  input  logic [FUNCT_W-1:0] req1_funct,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [XLEN-1:0]    rsp_data,
  output logic               rsp_err
);
  import alu_arbiter_pkg::*;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic              last_grant_q, last_grant_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;

  logic              free, grant0, grant1, accept, op_err;
  logic [XLEN-1:0]   alu_in1, alu_in2, alu_result;
  logic [FUNCT_W-1:0] alu_funct;

  // Grant is decided from the valids alone; the buffer state only gates ready.
  always_comb begin
    free       = !rsp_valid_q || rsp_ready;
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    grant0     = req0_valid && !grant1;
    req0_ready = free && grant0 && !flush;
    req1_ready = free && grant1 && !flush;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  assign alu_in1   = grant1 ? req1_in1   : req0_in1;
  assign alu_in2   = grant1 ? req1_in2   : req0_in2;
  assign alu_funct = grant1 ? req1_funct : req0_funct;
  assign op_err    = alu_unsupported(alu_funct);

  alu_arbiter_alu #(
    .XLEN    (XLEN),
    .FUNCT_W (FUNCT_W)
  ) u_alu (
    .in1_i    (alu_in1),
    .in2_i    (alu_in2),
    .funct_i  (alu_funct),
    .result_o (alu_result)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
    end else if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_err_d    = op_err;
      // Unsupported codes never let the ALU result through
      rsp_data_d   = op_err ? '0 : alu_result;
      last_grant_d = grant1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle model compared every cycle plus
// hand-computed expectations for each scenario.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_funct, req1_funct;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.XLEN(32), .FUNCT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_funct (req0_funct),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_funct (req1_funct),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the operation table: {err, data}
  function automatic logic [32:0] model_alu(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    casez (f)
      4'b0000: return {1'b0, a + b};
      4'b1000: return {1'b0, a - b};
      4'b?001: return {1'b0, a << b[4:0]};
      4'b?100: return {1'b0, a ^ b};
      4'b0101: return {1'b0, a >> b[4:0]};
      4'b1101: return {1'b0, $unsigned($signed(a) >>> b[4:0])};
      4'b?110: return {1'b0, a | b};
      4'b?111: return {1'b0, a & b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Model state: what the response buffer must hold
  logic        m_valid, m_id, m_err, m_last;
  logic [31:0] m_data;
  int          m_win;
  logic        m_any, m_free, m_take;
  logic [32:0] m_res;

  always_comb begin
    m_any  = req0_valid || req1_valid;
    m_free = !m_valid || rsp_ready;
    if (req0_valid && req1_valid) m_win = m_last ? 0 : 1;
    else                          m_win = req1_valid ? 1 : 0;
    m_take = m_any && m_free && !flush;
    m_res  = (m_win == 1) ? model_alu(req1_funct, req1_in1, req1_in2)
                          : model_alu(req0_funct, req0_in1, req0_in2);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_id <= 1'b0; m_err <= 1'b0; m_data <= 32'h0; m_last <= 1'b1;
    end else if (flush) begin
      m_valid <= 1'b0; m_err <= 1'b0;
    end else if (m_take) begin
      m_valid <= 1'b1;
      m_id    <= (m_win == 1);
      m_err   <= m_res[32];
      m_data  <= m_res[31:0];
      m_last  <= (m_win == 1);
    end else if (m_valid && rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
    chk("cmp rsp_id",    {31'h0, rsp_id},    {31'h0, m_id});
    chk("cmp rsp_err",   {31'h0, rsp_err},   {31'h0, m_err});
    chk("cmp rsp_data",  rsp_data,           m_data);
    chk("cmp req0_ready", {31'h0, req0_ready}, {31'h0, m_take && m_win == 0});
    chk("cmp req1_ready", {31'h0, req1_ready}, {31'h0, m_take && m_win == 1});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_funct = f; req0_in1 = a; req0_in2 = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_funct = f; req1_in1 = a; req1_in2 = b;
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic id,
                         input logic [31:0] d, input logic e);
    chk({name, " valid"}, {31'h0, rsp_valid}, {31'h0, v});
    chk({name, " id"},    {31'h0, rsp_id},    {31'h0, id});
    chk({name, " data"},  rsp_data,           d);
    chk({name, " err"},   {31'h0, rsp_err},   {31'h0, e});
  endtask

  task automatic chk_rdy(input string name, input logic r0, input logic r1);
    chk({name, " req0_ready"}, {31'h0, req0_ready}, {31'h0, r0});
    chk({name, " req1_ready"}, {31'h0, req1_ready}, {31'h0, r1});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    #3;
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    #9 rst_n = 1'b1;

    // Contention: port 0 wins first, then strict alternation
    step();
    drive0(1'b1, 4'b1000, 32'h17, 32'h0A);
    drive1(1'b1, 4'b0111, 32'h17, 32'h0A);
    @(negedge clk);
    chk_rdy("contend0", 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step();
      @(negedge clk);
      chk_rdy($sformatf("contend%0d", k), (k % 2) == 0, (k % 2) == 1);
      if ((k % 2) == 1) chk_rsp($sformatf("contend%0d rsp", k), 1'b1, 1'b0, 32'h0D, 1'b0);
      else              chk_rsp($sformatf("contend%0d rsp", k), 1'b1, 1'b1, 32'h02, 1'b0);
    end
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("contend last rsp", 1'b1, 1'b1, 32'h02, 1'b0);

    // Single request on a free buffer
    step();
    drive0(1'b1, 4'b0000, 32'h17, 32'h0A);
    @(negedge clk);
    chk_rdy("single", 1'b1, 1'b0);
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("single rsp", 1'b1, 1'b0, 32'h21, 1'b0);

    // Backpressure after an SRA; pending req1 taken the cycle ready returns
    step();
    drive0(1'b1, 4'b1101, 32'h80000015, 32'h3);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk_rdy("sra accept", 1'b1, 1'b0);
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b1, 4'b0100, 32'h17, 32'h0A);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk_rsp($sformatf("stall%0d", k), 1'b1, 1'b0, 32'hF0000002, 1'b0);
      chk_rdy($sformatf("stall%0d", k), 1'b0, 1'b0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_rdy("unstall", 1'b0, 1'b1);
    step();
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("xor rsp", 1'b1, 1'b1, 32'h1D, 1'b0);

    // Unsupported code is accepted but flagged, data forced to zero
    step();
    drive0(1'b1, 4'b0011, 32'h80000015, 32'h3);
    @(negedge clk);
    chk_rdy("bad op", 1'b1, 1'b0);
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("bad op rsp", 1'b1, 1'b0, 32'h0, 1'b1);

    // Flush beats a simultaneous accept and drain
    step();
    drive1(1'b1, 4'b0110, 32'h17, 32'h0A);
    step();
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    drive0(1'b1, 4'b0000, 32'h17, 32'h0A);
    flush = 1'b1;
    @(negedge clk);
    chk_rsp("pre flush", 1'b1, 1'b1, 32'h1F, 1'b0);
    chk_rdy("flush", 1'b0, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("post flush valid", {31'h0, rsp_valid}, 32'h0);
    chk_rdy("post flush", 1'b1, 1'b0);
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("post flush rsp", 1'b1, 1'b0, 32'h21, 1'b0);

    // Async reset in the middle of a stall
    step();
    drive1(1'b1, 4'b0001, 32'h17, 32'h24);
    @(negedge clk);
    chk_rdy("sll", 1'b0, 1'b1);
    step();
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk_rsp("sll stall", 1'b1, 1'b1, 32'h170, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_rsp("async reset", 1'b0, 1'b0, 32'h0, 1'b0);
    #5 rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b1, 4'b0000, 32'h17, 32'h0A);
    drive1(1'b1, 4'b0100, 32'h17, 32'h0A);
    @(negedge clk);
    chk_rdy("after reset", 1'b1, 1'b0);
    step();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_rsp("after reset rsp", 1'b1, 1'b0, 32'h21, 1'b0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
